frame_crc_check: RTL
====================

FRAME_CRC_CHECK -- requirements
Module: frame_crc_check

Interface
REQ-001 Parameter pMIN_LEN, default 64, minimum legal frame length in bytes, FCS included.
REQ-002 Parameter pMAX_LEN, default 1518, maximum legal frame length in bytes, FCS included.
REQ-003 iclk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 idv  input  1  byte-valid from frame_receiver o_dv; high for the whole frame, destination address through FCS, preamble/SFD excluded.
REQ-006 irx_d  input  8  frame byte from frame_receiver o_data, valid when idv=1.
REQ-007 i_error  input  1  frame_receiver o_error; abort of the current frame.
REQ-008 o_crc_val  output  1  one-cycle result strobe per frame.
REQ-009 o_crc_correct  output  1  FCS matched; drives the memory stage i_crc_correct.
REQ-010 o_len_err  output  1  length outside [pMIN_LEN, pMAX_LEN].
REQ-011 o_frame_ok  output  1  o_crc_correct and not o_len_err and no abort.
REQ-012 o_len  output  11  byte count of the frame, FCS included.
REQ-013 o_busy  output  1  high while a frame is being accumulated.

Function
REQ-014 The CRC SHALL be CRC-32 IEEE 802.3: reflected, polynomial 0xEDB88320, init 0xFFFFFFFF, LSB first, one full byte per cycle.
REQ-015 The CRC SHALL run over every byte with idv=1, FCS included; the FCS is good iff the register equals the residue 0xDEBB20E3 after the last byte.
REQ-016 FSM states SHALL be IDLE, RUN, DROP and DONE.
REQ-017 IDLE->RUN SHALL occur on idv=1 with i_error=0; that byte is processed with the register seeded to 0xFFFFFFFF and the count set to 1.
REQ-018 RUN SHALL process one byte and increment the count on every cycle with idv=1.
REQ-019 RUN->DONE SHALL occur on the first cycle with idv=0.
REQ-020 RUN->DROP SHALL occur on i_error=1; DROP SHALL ignore data until idv=0, then go to DONE with the abort flag set.
REQ-021 In DONE, o_crc_val SHALL be 1 for exactly one cycle, i.e. one cycle after the idv falling edge.
REQ-022 o_crc_correct, o_len_err, o_frame_ok and o_len SHALL be valid in that cycle and hold until the next DONE.
REQ-023 On abort, o_crc_correct=0 and o_frame_ok=0.
REQ-024 The byte count SHALL saturate at 2047; any count >pMAX_LEN SHALL set o_len_err.
REQ-025 If idv=1 in the DONE cycle, the FSM SHALL enter RUN and process that byte as the first byte of the next frame, back-to-back with one idle gap.
REQ-026 i_error=1 in IDLE with idv=1 SHALL enter DROP.
REQ-027 i_error=1 with idv=0 in IDLE SHALL be ignored.
REQ-028 o_busy SHALL be 1 in RUN and DROP, and 0 otherwise.

Reset
REQ-029 i_rst SHALL force IDLE, CRC register to 0xFFFFFFFF, count to 0, and all outputs to 0, including o_len=0.
REQ-030 Reset mid-frame SHALL discard the frame without a strobe.
REQ-031 After reset mid-frame, the remaining bytes with idv=1 SHALL be treated as a new frame starting on the first cycle after reset.

Structure
REQ-032 The CRC polynomial, init, residue and FSM state encodings SHALL live in shared package frame_pkg.
REQ-033 The pMIN_LEN/pMAX_LEN defaults SHALL also live in frame_pkg.
REQ-034 The byte-wide CRC next-state function SHALL be a combinational sub-module crc32_byte, with inputs crc 32 and data 8 and output crc 32.
REQ-035 crc32_byte SHALL be reusable by a future transmit-side FCS generator.

Verification
REQ-036 Bytes "123456789" (0x31..0x39) followed by 26 39 F4 CB -> o_crc_correct=1, o_len=13, o_len_err=1, o_frame_ok=0.
REQ-037 pcap2gmii test.pcap 64-byte frame with valid FCS -> o_crc_val one cycle after idv falls, o_crc_correct=1, o_len=64, o_frame_ok=1.
REQ-038 Same 64-byte frame with bit 0 of byte 20 flipped -> o_crc_correct=0, o_len=64, o_frame_ok=0.
REQ-039 i_error pulse at byte 30 of a 100-byte frame -> a single strobe after idv falls, o_crc_correct=0, o_frame_ok=0, o_len=30.
REQ-040 Two 64-byte good frames with a one-cycle idv gap -> two strobes 65 cycles apart, both o_frame_ok=1.
REQ-041 1600-byte frame -> o_len_err=1, o_len=1600.
REQ-042 i_rst at byte 10 -> no strobe for that frame, outputs 0, following frame checked correctly.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared constants for the receive-side frame checker: CRC-32 (IEEE 802.3,
// reflected) parameters, FSM state encodings, length limits and helpers.
package frame_pkg;

    localparam int LEN_W = 11;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int unsigned MIN_LEN_DEF = 32'd64;
    localparam int unsigned MAX_LEN_DEF = 32'd1518;

    localparam logic [LEN_W-1:0] LEN_SAT = 11'd2047;

    // Byte counter increment that sticks at the top of the 11-bit range.
    function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] cnt);
        logic [LEN_W-1:0] res;
        if (cnt == LEN_SAT) begin
            res = cnt;
        end else begin
            res = cnt + 11'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/crc32_byte.sv
// Byte-wide CRC-32 next-state function (reflected, LSB of the byte first).
// Purely combinational so the transmit-side FCS generator can share it.
module crc32_byte
    import frame_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] acc_s;

    // Shift the eight data bits through the reflected polynomial, bit 0 first.
    always_comb begin
        acc_s = crc;
        for (int i = 0; i < 8; i++) begin
            if (acc_s[0] ^ data[i]) begin
                acc_s = {1'b0, acc_s[31:1]} ^ CRC_POLY;
            end else begin
                acc_s = {1'b0, acc_s[31:1]};
            end
        end
        crc_next = acc_s;
    end

endmodule

// File: rtl/frame_crc_check.sv
// Receive-side FCS and length checker. Accumulates CRC-32 over every valid
// byte (FCS included), counts bytes, and emits a one-cycle result strobe the
// cycle after idv falls. Results hold until the next frame completes.
module frame_crc_check
    import frame_pkg::*;
#(
    parameter int unsigned pMIN_LEN = MIN_LEN_DEF,
    parameter int unsigned pMAX_LEN = MAX_LEN_DEF
)
(
    input  logic             iclk,
    input  logic             i_rst,
    input  logic             idv,
    input  logic [7:0]       irx_d,
    input  logic             i_error,
    output logic             o_crc_val,
    output logic             o_crc_correct,
    output logic             o_len_err,
    output logic             o_frame_ok,
    output logic [LEN_W-1:0] o_len,
    output logic             o_busy
);

    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(pMIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(pMAX_LEN);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [31:0]      crc_r;
    logic [31:0]      crc_nxt_s;
    logic [31:0]      crc_src_s;
    logic [31:0]      crc_upd_s;
    logic [LEN_W-1:0] count_r;
    logic [LEN_W-1:0] count_nxt_s;
    logic             abort_r;
    logic             abort_nxt_s;
    logic             done_s;
    logic             crc_ok_s;
    logic             len_err_s;

    // A new frame always starts from the init value; only RUN continues.
    assign crc_src_s = (state_r == ST_RUN) ? crc_r : CRC_INIT;

    crc32_byte u_crc (
        .crc      (crc_src_s),
        .data     (irx_d),
        .crc_next (crc_upd_s)
    );

    // Next-state, CRC, byte-count and abort-flag decode.
    always_comb begin
        state_nxt_s = state_r;
        crc_nxt_s   = crc_r;
        count_nxt_s = count_r;
        abort_nxt_s = abort_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (idv) begin
                    count_nxt_s = 11'd1;
                    if (i_error) begin
                        state_nxt_s = ST_DROP;
                        abort_nxt_s = 1'b1;
                        crc_nxt_s   = CRC_INIT;
                    end else begin
                        state_nxt_s = ST_RUN;
                        abort_nxt_s = 1'b0;
                        crc_nxt_s   = crc_upd_s;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!idv) begin
                    // An error coinciding with the end still aborts the frame.
                    state_nxt_s = ST_DONE;
                    abort_nxt_s = i_error;
                end else if (i_error) begin
                    state_nxt_s = ST_DROP;
                    abort_nxt_s = 1'b1;
                    count_nxt_s = len_inc(count_r);
                end else begin
                    crc_nxt_s   = crc_upd_s;
                    count_nxt_s = len_inc(count_r);
                end
            end
            ST_DROP: begin
                if (!idv) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Result evaluation for the cycle that enters DONE.
    always_comb begin
        done_s    = (state_nxt_s == ST_DONE);
        crc_ok_s  = (!abort_nxt_s) && (crc_r == CRC_RESIDUE);
        len_err_s = (count_r < MIN_L) || (count_r > MAX_L);
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge iclk) begin
        if (i_rst) begin
            state_r       <= ST_IDLE;
            crc_r         <= CRC_INIT;
            count_r       <= 11'd0;
            abort_r       <= 1'b0;
            o_crc_val     <= 1'b0;
            o_crc_correct <= 1'b0;
            o_len_err     <= 1'b0;
            o_frame_ok    <= 1'b0;
            o_len         <= 11'd0;
            o_busy        <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            crc_r     <= crc_nxt_s;
            count_r   <= count_nxt_s;
            abort_r   <= abort_nxt_s;
            o_crc_val <= done_s;
            o_busy    <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DROP);
            if (done_s) begin
                o_crc_correct <= crc_ok_s;
                o_len_err     <= len_err_s;
                o_frame_ok    <= crc_ok_s && !len_err_s;
                o_len         <= count_r;
            end else begin
                o_crc_correct <= o_crc_correct;
                o_len_err     <= o_len_err;
                o_frame_ok    <= o_frame_ok;
                o_len         <= o_len;
            end
        end
    end

endmodule
